// File: rtl/serial_to_parallel_receiver_8_bits_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package serial_receiver_pkg;

   typedef enum logic {IDLE, RECEIVE} rx_state_e;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   // Counter must reach DATA_WIDTH-1 and still show a full-width debug value.
   function automatic int unsigned count_width(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_to_parallel_receiver_8_bits_holding.sv
// Output holding register: one-deep valid/ready buffer with sticky overrun.
module serial_receiver_holding_register
   import serial_receiver_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load_req,
   input  logic [DATA_WIDTH-1:0] i_word,
   input  logic                  i_ready,
   input  logic                  i_clear,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_overrun
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_overrun;
   logic                  w_load;
   logic                  w_drop;

   // A held word may be replaced only on the same edge it is consumed.
   assign w_load = i_load_req && (!r_valid || i_ready);
   assign w_drop = i_load_req && r_valid && !i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load) begin
            r_data  <= i_word;
            r_valid <= 1'b1;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (i_clear) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_to_parallel_receiver_8_bits.sv
// Strobe-qualified, frame-synced serial deserializer feeding a one-word output buffer.
module serial_to_parallel_receiver_8_bits
   import serial_receiver_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter bit          LSB_FIRST  = 1'b1
) (
   input  logic                                 Clk_In,
   input  logic                                 Reset_In,
   input  logic                                 Serial_Data_In,
   input  logic                                 Bit_Valid_In,
   input  logic                                 Frame_Sync_In,
   input  logic                                 Data_Ready_In,
   input  logic                                 Clear_Status_In,
   output logic [DATA_WIDTH-1:0]                Parallel_Data_Out,
   output logic                                 Data_Valid_Out,
   output logic                                 Frame_Error_Out,
   output logic                                 Overrun_Out,
   output logic [count_width(DATA_WIDTH)-1:0]   Bit_Count_Out
);

   localparam int unsigned CW = count_width(DATA_WIDTH);
   localparam int unsigned IW = $clog2(DATA_WIDTH);
   localparam logic [IW-1:0] FIRST_IDX  = LSB_FIRST ? '0 : IW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

   rx_state_e             r_state, w_state_next;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
   logic [CW-1:0]         r_count, w_count_next;
   logic                  r_frame_err, w_frame_err_next;
   logic                  w_word_done;
   logic [DATA_WIDTH-1:0] w_word;
   logic [IW-1:0]         w_pos;

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_count     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_shift     <= w_shift_next;
         r_count     <= w_count_next;
         r_frame_err <= w_frame_err_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_shift_next     = r_shift;
      w_count_next     = r_count;
      w_frame_err_next = 1'b0;
      w_word_done      = 1'b0;
      w_word           = r_shift;
      w_pos            = LSB_FIRST ? r_count[IW-1:0] : IW'(DATA_WIDTH - 1) - r_count[IW-1:0];
      if (Bit_Valid_In) begin
         if (Frame_Sync_In) begin
            w_shift_next            = '0;
            w_shift_next[FIRST_IDX] = Serial_Data_In;
            w_count_next            = CW'(1);
            w_frame_err_next        = (r_state == RECEIVE);
            w_state_next            = RECEIVE;
         end else if (r_state == RECEIVE) begin
            w_shift_next[w_pos] = Serial_Data_In;
            // Completing bit is merged before the word leaves for the buffer.
            if (r_count == LAST_COUNT) begin
               w_word       = w_shift_next;
               w_word_done  = 1'b1;
               w_shift_next = '0;
               w_count_next = '0;
               w_state_next = IDLE;
            end else begin
               w_count_next = r_count + CW'(1);
            end
         end
      end
   end

   serial_receiver_holding_register #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_hold (
      .i_clk     (Clk_In),
      .i_rst     (Reset_In),
      .i_load_req(w_word_done),
      .i_word    (w_word),
      .i_ready   (Data_Ready_In),
      .i_clear   (Clear_Status_In),
      .o_data    (Parallel_Data_Out),
      .o_valid   (Data_Valid_Out),
      .o_overrun (Overrun_Out)
   );

   assign Frame_Error_Out = r_frame_err;
   assign Bit_Count_Out   = r_count;

endmodule

// File: tb/tb_serial_to_parallel_receiver_8_bits.sv
// Directed plus randomized bench for serial_to_parallel_receiver_8_bits against a queue-based model.
module tb_serial_to_parallel_receiver_8_bits;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sdata = 1'b0, bvalid = 1'b0, fsync = 1'b0, ready = 1'b0, clr = 1'b0;
   logic [DW-1:0] pdata;
   logic          dvalid, ferr, ovr;
   logic [3:0]    bcount;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int            m_bits[$];
   bit            m_in_word;
   logic [DW-1:0] m_data;
   bit            m_valid, m_ovr, m_ferr;

   serial_to_parallel_receiver_8_bits #(
      .DATA_WIDTH(DW),
      .LSB_FIRST (1'b1)
   ) dut (
      .Clk_In           (clk),
      .Reset_In         (rst),
      .Serial_Data_In   (sdata),
      .Bit_Valid_In     (bvalid),
      .Frame_Sync_In    (fsync),
      .Data_Ready_In    (ready),
      .Clear_Status_In  (clr),
      .Parallel_Data_Out(pdata),
      .Data_Valid_Out   (dvalid),
      .Frame_Error_Out  (ferr),
      .Overrun_Out      (ovr),
      .Bit_Count_Out    (bcount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_in_word = 0;
      m_data    = '0;
      m_valid   = 0;
      m_ovr     = 0;
      m_ferr    = 0;
   endtask

   task automatic model_edge(input bit v, input bit d, input bit s, input bit rdy, input bit cl);
      bit load_req = 0;
      bit fe = 0;
      bit drop;
      int acc = 0;
      if (v) begin
         if (s) begin
            fe = m_in_word;
            m_bits.delete();
            m_bits.push_back(int'(d));
            m_in_word = 1;
         end else if (m_in_word) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() == DW) begin
               foreach (m_bits[k]) acc = acc + m_bits[k] * (1 << k);
               load_req = 1;
               m_bits.delete();
               m_in_word = 0;
            end
         end
      end
      drop = load_req && m_valid && !rdy;
      if (load_req && !drop) begin
         m_data  = acc[DW-1:0];
         m_valid = 1;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      if (drop) m_ovr = 1;
      else if (cl) m_ovr = 0;
      m_ferr = fe;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data"},  32'(pdata),  32'(m_data));
      chk({tag, ".valid"}, 32'(dvalid), 32'(m_valid));
      chk({tag, ".ferr"},  32'(ferr),   32'(m_ferr));
      chk({tag, ".ovr"},   32'(ovr),    32'(m_ovr));
      chk({tag, ".count"}, 32'(bcount), m_in_word ? 32'(m_bits.size()) : 32'd0);
   endtask

   task automatic step(input bit v, input bit d, input bit s, input bit rdy, input bit cl, input string tag);
      @(negedge clk);
      bvalid = v; sdata = d; fsync = s; ready = rdy; clr = cl;
      @(posedge clk);
      model_edge(v, d, s, rdy, cl);
      #1;
      check_all(tag);
   endtask

   task automatic send_word(input logic [DW-1:0] w, input int gap, input bit rdy_last, input string tag);
      for (int k = 0; k < DW; k++) begin
         if (k != 0) begin
            for (int g = 0; g < gap; g++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, tag);
         end
         step(1, w[k], k == 0, (k == DW - 1) ? rdy_last : 1'b0, 0, tag);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".data"},  32'(pdata),  32'd0);
      chk({tag, ".valid"}, 32'(dvalid), 32'd0);
      chk({tag, ".ferr"},  32'(ferr),   32'd0);
      chk({tag, ".ovr"},   32'(ovr),    32'd0);
      chk({tag, ".count"}, 32'(bcount), 32'd0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: first word, held while not ready
      send_word(8'hA5, 0, 0, "t1");
      chk("t1.word", 32'(pdata), 32'hA5);
      chk("t1.valid", 32'(dvalid), 32'd1);
      step(0, 0, 0, 0, 0, "t1.hold");
      step(0, 0, 0, 0, 0, "t1.hold");

      // 2: overrun, consume, clear
      send_word(8'h3C, 0, 0, "t2");
      chk("t2.ovr", 32'(ovr), 32'd1);
      chk("t2.keep", 32'(pdata), 32'hA5);
      step(0, 0, 0, 1, 0, "t2.consume");
      chk("t2.valid", 32'(dvalid), 32'd0);
      step(0, 0, 0, 0, 1, "t2.clear");
      chk("t2.cleared", 32'(ovr), 32'd0);

      // 3: resync mid-word
      step(1, 1, 1, 0, 0, "t3.part");
      step(1, 0, 0, 0, 0, "t3.part");
      step(1, 1, 0, 0, 0, "t3.part");
      step(1, 1, 1, 0, 0, "t3.sync");
      chk("t3.ferr", 32'(ferr), 32'd1);
      for (int k = 1; k < DW; k++) step(1, k == DW - 1, 0, 0, 0, "t3.rest");
      chk("t3.word", 32'(pdata), 32'h81);
      chk("t3.ovr", 32'(ovr), 32'd0);

      // 4: unsynced bits ignored, then gapped word
      step(0, 0, 0, 1, 0, "t4.consume");
      for (int k = 0; k < 5; k++) step(1, 1'($urandom_range(0, 1)), 0, 0, 0, "t4.idle");
      chk("t4.count", 32'(bcount), 32'd0);
      chk("t4.valid", 32'(dvalid), 32'd0);
      send_word(8'hFF, 2, 0, "t4");
      chk("t4.word", 32'(pdata), 32'hFF);

      // 5: simultaneous consume and load
      step(0, 0, 0, 1, 0, "t5.consume");
      send_word(8'h11, 0, 0, "t5a");
      send_word(8'h22, 0, 1, "t5b");
      chk("t5.word", 32'(pdata), 32'h22);
      chk("t5.valid", 32'(dvalid), 32'd1);
      chk("t5.ovr", 32'(ovr), 32'd0);

      // 6: asynchronous reset mid-word
      step(0, 0, 0, 1, 0, "t6.consume");
      step(1, 0, 1, 0, 0, "t6.part");
      for (int k = 1; k < 4; k++) step(1, 1'($urandom_range(0, 1)), 0, 0, 0, "t6.part");
      #2;
      rst = 1'b1;
      #1;
      check_zero("t6.async");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      send_word(8'h5A, 0, 0, "t6");
      chk("t6.word", 32'(pdata), 32'h5A);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit v;
         v = ($urandom_range(0, 3) != 0);
         step(v, 1'($urandom_range(0, 1)), v && ($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_to_parallel_receiver_8_bits.md
Name: serial_to_parallel_receiver_8_bits

Overview:
Downstream stage of the 8-bit PISO shift register. Deserializes the LSB-first serial stream back into parallel words. Presents each completed word on a valid/ready output with one holding register. Bits are qualified by a strobe, and a frame-sync marks bit 0 of each word. Reports framing errors and overruns.

Parameters:
DATA_WIDTH, 8, bits per word (2..15).
LSB_FIRST, 1, 1 = first received bit lands in bit 0 (matches PISO); 0 = first bit lands in MSB.

Ports:
Clk_In  input  1  clock, all state updates on posedge.
Reset_In  input  1  asynchronous, active-high reset.
Serial_Data_In  input  1  serial data bit.
Bit_Valid_In  input  1  qualifies Serial_Data_In; a bit is accepted on a posedge where this is 1.
Frame_Sync_In  input  1  with Bit_Valid_In=1, marks the accepted bit as bit 0 of a new word; ignored when Bit_Valid_In=0.
Data_Ready_In  input  1  consumer accepts Parallel_Data_Out.
Clear_Status_In  input  1  clears sticky Overrun_Out.
Parallel_Data_Out  output  DATA_WIDTH  held word.
Data_Valid_Out  output  1  Parallel_Data_Out is valid.
Frame_Error_Out  output  1  one-cycle pulse on sync during a partial word.
Overrun_Out  output  1  sticky; a completed word was dropped.
Bit_Count_Out  output  $clog2(DATA_WIDTH)+1  debug: bits collected in the current word.

Behaviour:
- Reset (async, any time, including mid-word): state IDLE, shift register 0, Bit_Count_Out 0, Parallel_Data_Out 0, Data_Valid_Out 0, Frame_Error_Out 0, Overrun_Out 0.
- States:
  - IDLE: accepted bits without sync are ignored. An accepted bit with sync stores bit 0, sets count=1, and moves to RECEIVE.
  - RECEIVE: each accepted bit without sync is stored at position count, then count increments.
  - RECEIVE, accepted bit with sync: discard the partial word, store the bit as bit 0, set count=1, pulse Frame_Error_Out next cycle, stay in RECEIVE.
- Bit placement: LSB_FIRST=1 places bit k at index k; LSB_FIRST=0 places bit k at index DATA_WIDTH-1-k.
- Word completion happens on the edge accepting bit DATA_WIDTH-1. That same edge does the following:
  - The assembled word, including the incoming bit, is offered to the holding register.
  - Count returns to 0 and the state returns to IDLE; the next word needs a new sync.
- Latency: Data_Valid_Out rises on the posedge that accepts the last bit, i.e. it is visible in the cycle after the last bit is presented.
- Holding register load:
  - Loads if Data_Valid_Out=0, or if Data_Valid_Out=1 and Data_Ready_In=1 on that edge (simultaneous consume and load; valid stays 1).
  - Otherwise the new word is dropped, Overrun_Out is set, and the held word is unchanged.
- Handshake: the transfer occurs on a posedge with Data_Valid_Out=1 and Data_Ready_In=1.
  - Without a simultaneous load, Data_Valid_Out falls on that edge.
  - Parallel_Data_Out is stable while valid=1 and ready=0.
- Overrun_Out clears on a posedge with Clear_Status_In=1, unless an overrun occurs on that same edge; set wins.
- Bit_Valid_In=0 cycles (gaps) freeze the count and state. Arbitrary gaps are legal.
- Serial input is launched by the PISO on negedge; sampling on posedge gives half-cycle margin.

Decomposition:
- Shared package serial_receiver_pkg holds:
  - state enum {IDLE, RECEIVE};
  - default DATA_WIDTH constant;
  - count-width function.
- One sub-module: serial_receiver_holding_register, which contains the output register, valid flag, load/consume/overrun logic.
- The top level contains the FSM, shift register, and counter.

Test Plan:
1. Reset, then send 0xA5 LSB-first (1,0,1,0,0,1,0,1) with sync on the first bit, Data_Ready_In=0 -> Parallel_Data_Out=0xA5 and Data_Valid_Out=1 the cycle after the 8th bit; held until ready; Bit_Count_Out goes 1..7 then 0.
2. Keep ready=0 and send 0x3C -> Overrun_Out=1, output stays 0xA5. Then ready=1 for one cycle -> valid=0. Then Clear_Status_In=1 -> Overrun_Out=0.
3. Send 3 bits, then sync with 0x81 -> Frame_Error_Out pulses one cycle; output=0x81, no overrun.
4. 5 bits without sync while in IDLE -> count stays 0, no valid. Then 0xFF with 2-cycle gaps between bits -> 0xFF valid.
5. Back-to-back: valid=1 holding 0x11, ready=1 on the edge completing 0x22 -> output 0x22, valid stays 1, no overrun.
6. Assert Reset_In asynchronously mid-word (after 4 bits) -> all outputs 0 immediately. The next synced 0x5A is received correctly.
